inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage directly upstream of the instruction decoder. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency. It buffers up to two fetched words with their PCs and presents them to decode as `Instruction`. It also accepts a downstream stall and a redirect (jump/branch target) that flushes everything fetched on the wrong path.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request; registered; held high until ack.
- `imem_addr` output 32: fetch byte address; registered; stable while `imem_req` is high.
- `imem_ack` input 1: memory completion; sampled only while `imem_req` is high.
- `imem_rdata` input 32: instruction word; valid in the `imem_ack` cycle.
- `stall` input 1: decode cannot accept this cycle.
- `redirect` input 1: one-cycle pulse to flush and restart fetch.
- `redirect_pc` input 32: new fetch address; valid with `redirect`.
- `inst_valid` output 1: the buffer head is valid.
- `Instruction` output 32: buffer head word, fed to the decoder.
- `inst_pc` output 32: byte address of `Instruction`.

## Operation
- State is `fetch_pc`, a two-entry FIFO of {word, pc} with `count` 0..2, and an FSM with states IDLE, WAIT and DROP.
- The head entry drives `inst_valid`, `Instruction` and `inst_pc` directly from registers. `inst_valid` = (`count` != 0).
- **Pop rule:** when `inst_valid && !stall && !redirect`, the head is consumed at the edge.
- At most one request is outstanding. A request may start only if `count_next` <= 1, which guarantees the FIFO has space when the ack arrives.
- **IDLE:**
  - If `redirect`: set `fetch_pc` = `redirect_pc` and flush the FIFO.
  - Otherwise, if there is space: set `imem_req`=1, `imem_addr`=`fetch_pc`, and go to WAIT.
- **WAIT, on `imem_ack` without `redirect`:**
  - Push {`imem_rdata`, `imem_addr`} and set `fetch_pc` += 4 (wraps mod 2^32).
  - If `count_next` <= 1 after push and pop: stay in WAIT with `imem_addr` = new `fetch_pc`, giving back-to-back fetches.
  - Otherwise: drop `imem_req` and go to IDLE.
- **WAIT with `redirect` and no ack:** flush the FIFO, latch `redirect_pc` into `fetch_pc`, and go to DROP. `imem_req` and `imem_addr` stay unchanged until the ack.
- **WAIT with `redirect` and `imem_ack` in the same cycle:** discard `imem_rdata` and flush. Then `imem_req`=1, `imem_addr`=`redirect_pc`, and stay in WAIT.
- **DROP, on `imem_ack`:** discard the data. Then `imem_req`=1, `imem_addr`=`fetch_pc`, and go to WAIT.
- **DROP, on a second `redirect`:** overwrite `fetch_pc` only. The last redirect wins.
- **Priority:** `redirect` > ack/push > pop/`stall`. The FIFO is never written while full, and a pop on empty is a no-op.
- **Misaligned addresses:** `redirect_pc[1:0]` is forced to 0.

## Timing
- **Reset values (asynchronous, applied immediately):**
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `inst_valid`=0, `Instruction`=0, `inst_pc`=0.
  - `count`=0, `fetch_pc`=`RESET_PC`, FSM=IDLE.
- **Reset mid-request:** the outstanding request is abandoned and `imem_req` falls immediately.
- **First request:** `imem_req` rises at the first rising edge after `rst_n` deasserts.
- **Fetch latency:** ack in cycle N gives `inst_valid` high in cycle N+1. The minimum is 2 cycles from reset release to the first valid instruction.
- **Throughput:** with ack asserted every cycle and no stall, one instruction per cycle and `count` settles at 1.
- **Redirect:**
  - With no request outstanding: the next request to `redirect_pc` is issued at the following edge, and `inst_valid` is 0 in the cycle after the redirect.
  - From DROP: the restart request is issued at the edge after the stale ack.
- **Stall:** `Instruction` and `inst_pc` stay stable while `stall` is high. The FIFO fills to 2, then `imem_req` drops.

## Test plan
- **Reset and streaming:** `RESET_PC`=0x100, memory acks in the same cycle with word = address. Required: `inst_pc` sequence 0x100, 0x104, 0x108, one per cycle; `Instruction` equals `inst_pc`; first `inst_valid` 2 cycles after reset release.
- **Stall fill:** assert `stall` for 6 cycles during streaming. Required: `count` reaches 2, `imem_req` falls, the head is held; after release the PCs continue with no gap or duplicate.
- **Redirect while idle and full:** pulse `redirect` with `redirect_pc`=0x2000. Required: the FIFO is flushed, the next `imem_addr`=0x2000, and the next valid `inst_pc`=0x2000.
- **Redirect with request outstanding:** 3-cycle memory latency, redirect to 0x40 one cycle after the request to 0x10. Required: the 0x10 data never appears, `imem_req` stays high at 0x10 until its ack, then the request goes to 0x40.
- **Redirect same cycle as ack:** the ack for 0x8 coincides with redirect to 0x80. Required: 0x8 is discarded and the next request is 0x80 with no idle cycle.
- **Wrap and async reset:** `RESET_PC`=0xFFFFFFFC. Required: the second fetch address is 0x0. Asserting `rst_n` low mid-WAIT drops all outputs to their reset values immediately.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding req/ack fetch
// at a time, buffers up to two {word, pc} entries for decode, and handles
// stall and redirect (wrong-path flush).
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] Instruction,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        req_next;
  logic [31:0] addr_next;

  // Two-entry FIFO kept as a shift pair: entry 0 is always the head.
  logic [31:0] word0, word1, pc0, pc1;
  logic [31:0] word0_next, word1_next, pc0_next, pc1_next;
  logic [1:0]  count, count_next;
  logic [1:0]  slot;

  logic        pop, push;
  logic [31:0] rpc;

  assign inst_valid  = (count != 2'd0);
  assign Instruction = word0;
  assign inst_pc     = pc0;

  // FIFO bookkeeping: redirect flushes, otherwise push/pop update occupancy.
  always_comb begin
    rpc        = redirect_pc & 32'hFFFF_FFFC;
    pop        = (count != 2'd0) && !stall && !redirect;
    push       = (state == WAIT) && imem_ack && !redirect;
    word0_next = word0;
    word1_next = word1;
    pc0_next   = pc0;
    pc1_next   = pc1;
    slot       = count - {1'b0, pop};
    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count + {1'b0, push} - {1'b0, pop};
    end
    if (pop) begin
      word0_next = word1;
      pc0_next   = pc1;
    end
    // Requests only start when space is guaranteed, so slot is 0 or 1 here.
    if (push) begin
      if (slot == 2'd0) begin
        word0_next = imem_rdata;
        pc0_next   = imem_addr;
      end else begin
        word1_next = imem_rdata;
        pc1_next   = imem_addr;
      end
    end
  end

  // Fetch FSM next-state, PC and request generation.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = imem_req;
    addr_next     = imem_addr;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = rpc;
        end else if (count_next <= 2'd1) begin
          req_next   = 1'b1;
          addr_next  = fetch_pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect && imem_ack) begin
          // Data belongs to the wrong path; reissue immediately at the target.
          fetch_pc_next = rpc;
          addr_next     = rpc;
          req_next      = 1'b1;
        end else if (redirect) begin
          // Request must complete unchanged; remember the target meanwhile.
          fetch_pc_next = rpc;
          state_next    = DROP;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc + 32'd4;
          if (count_next <= 2'd1) begin
            addr_next = fetch_pc + 32'd4;
          end else begin
            req_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_next = rpc;
        end
        if (imem_ack) begin
          req_next   = 1'b1;
          addr_next  = redirect ? rpc : fetch_pc;
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, PC, request and FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      count     <= '0;
      word0     <= '0;
      word1     <= '0;
      pc0       <= '0;
      pc1       <= '0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
      count     <= count_next;
      word0     <= word0_next;
      word1     <= word1_next;
      pc0       <= pc0_next;
      pc1       <= pc1_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, stall fill, redirects and PC wrap.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] Instruction, inst_pc;

  logic        rst_w_n;
  logic        req_w, ack_w;
  logic [31:0] addr_w, rdata_w;
  logic        stall_w = 1'b0;
  logic        redirect_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'h0;
  logic        valid_w;
  logic [31:0] insn_w, pc_w;

  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Memory model: acks after 'lat' extra cycles of request, word = address.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;
  assign ack_w      = req_w;
  assign rdata_w    = addr_w;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .Instruction(Instruction), .inst_pc(inst_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_w_n),
    .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w),
    .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .inst_valid(valid_w), .Instruction(insn_w), .inst_pc(pc_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; rst_w_n = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #3;
    rst_n = 1'b0; rst_w_n = 1'b0;
    tick;
    tick;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_insn", Instruction, 32'h0);
    check("rst_pc", inst_pc, 32'h0);

    // Reset release and streaming
    rst_n = 1'b1;
    tick;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h100);
    check("first_valid_early", {31'h0, inst_valid}, 32'h0);
    tick;
    check("first_valid", {31'h0, inst_valid}, 32'h1);
    for (int unsigned k = 0; k < 4; k++) begin
      check("stream_pc", inst_pc, 32'h100 + 4 * k);
      check("stream_insn", Instruction, 32'h100 + 4 * k);
      if (k != 3) tick;
    end

    // Stall fill
    stall = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      tick;
      check("stall_hold_pc", inst_pc, 32'h10C);
      check("stall_hold_valid", {31'h0, inst_valid}, 32'h1);
    end
    check("stall_req_low", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      tick;
      check("resume_pc", inst_pc, 32'h110 + 4 * k);
    end

    // Redirect while idle and full (misaligned target)
    stall = 1'b1;
    tick;
    check("full_req_low", {31'h0, imem_req}, 32'h0);
    check("full_head", inst_pc, 32'h118);
    redirect = 1'b1; redirect_pc = 32'h2003;
    tick;
    redirect = 1'b0; stall = 1'b0;
    check("rdi_flush", {31'h0, inst_valid}, 32'h0);
    check("rdi_noreq", {31'h0, imem_req}, 32'h0);
    tick;
    check("rdi_req", {31'h0, imem_req}, 32'h1);
    check("rdi_addr", imem_addr, 32'h2000);
    tick;
    check("rdi_valid", {31'h0, inst_valid}, 32'h1);
    check("rdi_pc", inst_pc, 32'h2000);
    check("rdi_insn", Instruction, 32'h2000);

    // Redirect with request outstanding (3-cycle latency)
    stall = 1'b1; lat = 2;
    tick; tick; tick;
    check("lat_fill_req", {31'h0, imem_req}, 32'h0);
    check("lat_fill_head", inst_pc, 32'h2000);
    redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b0;
    tick;
    redirect = 1'b0;
    check("out_flush", {31'h0, inst_valid}, 32'h0);
    tick;
    check("out_req10", {31'h0, imem_req}, 32'h1);
    check("out_addr10", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick;
    redirect = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      check("drop_req", {31'h0, imem_req}, 32'h1);
      check("drop_addr", imem_addr, 32'h10);
      check("drop_valid", {31'h0, inst_valid}, 32'h0);
      tick;
    end
    check("restart_req", {31'h0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h40);
    check("restart_valid", {31'h0, inst_valid}, 32'h0);
    tick; tick;
    check("restart_wait_valid", {31'h0, inst_valid}, 32'h0);
    tick;
    check("restart_got_valid", {31'h0, inst_valid}, 32'h1);
    check("restart_got_pc", inst_pc, 32'h40);
    check("restart_got_insn", Instruction, 32'h40);

    // Redirect coinciding with ack
    lat = 0; redirect = 1'b1; redirect_pc = 32'h8;
    tick;
    check("same_req8", {31'h0, imem_req}, 32'h1);
    check("same_addr8", imem_addr, 32'h8);
    check("same_valid8", {31'h0, inst_valid}, 32'h0);
    redirect_pc = 32'h80;
    tick;
    redirect = 1'b0;
    check("same_req80", {31'h0, imem_req}, 32'h1);
    check("same_addr80", imem_addr, 32'h80);
    check("same_discard8", {31'h0, inst_valid}, 32'h0);
    tick;
    check("same_valid80", {31'h0, inst_valid}, 32'h1);
    check("same_pc80", inst_pc, 32'h80);
    check("same_next_addr", imem_addr, 32'h84);

    // PC wrap and asynchronous reset mid-WAIT
    rst_w_n = 1'b1;
    tick;
    check("wrap_req", {31'h0, req_w}, 32'h1);
    check("wrap_addr0", addr_w, 32'hFFFF_FFFC);
    tick;
    check("wrap_pc0", pc_w, 32'hFFFF_FFFC);
    check("wrap_insn0", insn_w, 32'hFFFF_FFFC);
    check("wrap_addr1", addr_w, 32'h0);
    #2;
    rst_w_n = 1'b0;
    #1;
    check("arst_req", {31'h0, req_w}, 32'h0);
    check("arst_addr", addr_w, 32'hFFFF_FFFC);
    check("arst_valid", {31'h0, valid_w}, 32'h0);
    check("arst_insn", insn_w, 32'h0);
    check("arst_pc", pc_w, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
